// File: rtl/run_sequencer.sv
// rtl/run_sequencer.sv - CPU reset/run controller: reset pulse, run timing, halt capture, run repeat
module run_sequencer #(
    parameter int CNT_W       = 8,
    parameter int RST_CYCLES  = 2,
    parameter int RUN_CYCLES  = 30,
    parameter int NUM_RUNS    = 0,
    parameter int STOP_ON_HLT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hlt,
    output logic             cpu_rst,
    output logic [CNT_W-1:0] cycleNum,
    output logic             running,
    output logic             done,
    output logic             run_end,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] hlt_cycle,
    output logic [7:0]       run_idx,
    output logic             cyc_wrap
);
    localparam int PH_MAX = (RST_CYCLES > RUN_CYCLES) ? RST_CYCLES : RUN_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam logic [PH_W-1:0] RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] RUN_LAST = PH_W'(RUN_CYCLES - 1);

    typedef enum logic [1:0] {RST_PH, RUN, DONE} state_t;

    state_t          state;
    logic [PH_W-1:0] phase;

    logic       stop_hlt;
    logic       run_stop;
    logic [7:0] idx_next;
    logic       last_run;

    assign stop_hlt = hlt && (STOP_ON_HLT != 0);
    assign run_stop = stop_hlt || (phase == RUN_LAST);
    assign idx_next = (run_idx == 8'hff) ? run_idx : run_idx + 8'd1;
    assign last_run = (NUM_RUNS != 0) && (idx_next == 8'(NUM_RUNS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RST_PH;
            phase     <= '0;
            cpu_rst   <= 1'b1;
            cycleNum  <= CNT_W'(1);
            running   <= 1'b0;
            done      <= 1'b0;
            run_end   <= 1'b0;
            halted    <= 1'b0;
            timeout   <= 1'b0;
            hlt_cycle <= '0;
            run_idx   <= 8'd0;
            cyc_wrap  <= 1'b0;
        end else begin
            case (state)
                RST_PH: begin
                    run_end <= 1'b0;
                    if (phase == RST_LAST) begin
                        // Per-run status from the previous run stays visible until the new run starts.
                        state     <= RUN;
                        phase     <= '0;
                        cpu_rst   <= 1'b0;
                        running   <= 1'b1;
                        cycleNum  <= CNT_W'(1);
                        halted    <= 1'b0;
                        hlt_cycle <= '0;
                        timeout   <= 1'b0;
                        cyc_wrap  <= 1'b0;
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                RUN: begin
                    if (hlt && !halted) begin
                        halted    <= 1'b1;
                        hlt_cycle <= cycleNum;
                    end
                    if (run_stop) begin
                        run_end <= 1'b1;
                        run_idx <= idx_next;
                        timeout <= !stop_hlt;
                        phase   <= '0;
                        cpu_rst <= 1'b1;
                        running <= 1'b0;
                        if (last_run) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= RST_PH;
                            cycleNum <= CNT_W'(1);
                        end
                    end else begin
                        cycleNum <= cycleNum + 1'b1;
                        phase    <= phase + 1'b1;
                        if (&cycleNum) cyc_wrap <= 1'b1;
                    end
                end
                DONE: begin
                    run_end <= 1'b0;
                end
                default: begin
                    state <= RST_PH;
                    phase <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_run_sequencer.sv
// tb/tb_run_sequencer.sv - randomized + directed check of run_sequencer against a behavioural model
module tb_run_sequencer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, hlt0 = 1'b0, rst1 = 1'b1, hlt1 = 1'b0;

    logic       c0_cpu_rst, c0_running, c0_done, c0_run_end, c0_halted, c0_timeout, c0_cyc_wrap;
    logic [7:0] c0_cn, c0_hc, c0_idx;
    logic       c1_cpu_rst, c1_running, c1_done, c1_run_end, c1_halted, c1_timeout, c1_cyc_wrap;
    logic [2:0] c1_cn, c1_hc;
    logic [7:0] c1_idx;

    run_sequencer dut0 (
        .clk(clk), .rst(rst0), .hlt(hlt0), .cpu_rst(c0_cpu_rst), .cycleNum(c0_cn),
        .running(c0_running), .done(c0_done), .run_end(c0_run_end), .halted(c0_halted),
        .timeout(c0_timeout), .hlt_cycle(c0_hc), .run_idx(c0_idx), .cyc_wrap(c0_cyc_wrap)
    );

    run_sequencer #(.CNT_W(3), .RST_CYCLES(1), .RUN_CYCLES(10), .NUM_RUNS(3), .STOP_ON_HLT(0)) dut1 (
        .clk(clk), .rst(rst1), .hlt(hlt1), .cpu_rst(c1_cpu_rst), .cycleNum(c1_cn),
        .running(c1_running), .done(c1_done), .run_end(c1_run_end), .halted(c1_halted),
        .timeout(c1_timeout), .hlt_cycle(c1_hc), .run_idx(c1_idx), .cyc_wrap(c1_cyc_wrap)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    function automatic int p_cw(int i);   return (i == 0) ? 8 : 3;  endfunction
    function automatic int p_rst(int i);  return (i == 0) ? 2 : 1;  endfunction
    function automatic int p_run(int i);  return (i == 0) ? 30 : 10; endfunction
    function automatic int p_nr(int i);   return (i == 0) ? 0 : 3;  endfunction
    function automatic bit p_soh(int i);  return (i == 0); endfunction

    // Model: mode 0 = reset phase, 1 = running, 2 = done; t is the unwrapped cycle count of the latest run.
    int m_mode[2] = '{0, 0};
    int m_k[2]    = '{0, 0};
    int m_t[2]    = '{1, 1};
    int m_runs[2] = '{0, 0};
    int m_hc[2]   = '{0, 0};
    bit m_halted[2] = '{0, 0};
    bit m_to[2]     = '{0, 0};
    bit m_end[2]    = '{0, 0};

    task automatic model_step(input int i, input bit r, input bit h);
        bit ending;
        if (r) begin
            m_mode[i] = 0; m_k[i] = 0; m_t[i] = 1; m_runs[i] = 0;
            m_hc[i] = 0; m_halted[i] = 0; m_to[i] = 0; m_end[i] = 0;
        end else if (m_mode[i] == 0) begin
            m_end[i] = 0;
            m_k[i]++;
            if (m_k[i] == p_rst(i)) begin
                m_mode[i] = 1; m_t[i] = 1; m_halted[i] = 0; m_hc[i] = 0; m_to[i] = 0;
            end
        end else if (m_mode[i] == 1) begin
            ending = (h && p_soh(i)) || (m_t[i] == p_run(i));
            if (h && !m_halted[i]) begin
                m_halted[i] = 1;
                m_hc[i] = m_t[i] % (1 << p_cw(i));
            end
            if (ending) begin
                m_end[i] = 1;
                if (m_runs[i] < 255) m_runs[i]++;
                m_to[i] = !(h && p_soh(i));
                m_k[i] = 0;
                m_mode[i] = (p_nr(i) != 0 && m_runs[i] == p_nr(i)) ? 2 : 0;
            end else begin
                m_t[i]++;
            end
        end else begin
            m_end[i] = 0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0, rst0, hlt0);
        model_step(1, rst1, hlt1);
    end

    function automatic logic [30:0] expect_vec(int i);
        int cn;
        cn = (m_mode[i] == 0) ? 1 : m_t[i] % (1 << p_cw(i));
        return {m_mode[i] != 1, m_mode[i] == 1, m_mode[i] == 2, m_end[i], m_halted[i], m_to[i],
                m_t[i] >= (1 << p_cw(i)), 8'(cn), 8'(m_hc[i]), 8'(m_runs[i])};
    endfunction

    always @(negedge clk) begin
        logic [30:0] a0, a1, e0, e1;
        if (chk_en) begin
            a0 = {c0_cpu_rst, c0_running, c0_done, c0_run_end, c0_halted, c0_timeout, c0_cyc_wrap,
                  c0_cn, c0_hc, c0_idx};
            a1 = {c1_cpu_rst, c1_running, c1_done, c1_run_end, c1_halted, c1_timeout, c1_cyc_wrap,
                  5'd0, c1_cn, 5'd0, c1_hc, c1_idx};
            e0 = expect_vec(0);
            e1 = expect_vec(1);
            n_tests += 2;
            if (a0 !== e0) begin
                n_fail++;
                $display("FAIL model_dut0 t=%0t actual=%h required=%h", $time, a0, e0);
            end
            if (a1 !== e1) begin
                n_fail++;
                $display("FAIL model_dut1 t=%0t actual=%h required=%h", $time, a1, e1);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit cond(int inst, int kind, int val);
        if (inst == 0) begin
            if (kind == 0) return c0_running && (int'(c0_cn) == val);
            if (kind == 1) return c0_run_end;
            return c0_done;
        end
        if (kind == 0) return c1_running && (int'(c1_cn) == val);
        if (kind == 1) return c1_run_end;
        return c1_done;
    endfunction

    task automatic wait_cond(input int inst, input int kind, input int val);
        int n = 0;
        while (!cond(inst, kind, val) && n < 500) begin
            tick();
            n++;
        end
        n_tests++;
        if (!cond(inst, kind, val)) begin
            n_fail++;
            $display("FAIL wait_timeout inst=%0d kind=%0d val=%0d actual=expired required=event", inst, kind, val);
        end
    endtask

    initial begin
        tick();
        chk_en = 1'b1;
        tick();
        chk("reset_cpu_rst", c0_cpu_rst, 1);
        chk("reset_cycleNum", c0_cn, 1);
        chk("reset_run_idx", c0_idx, 0);
        rst0 = 1'b0;

        wait_cond(0, 0, 30);
        chk("run1_cpu_rst_low", c0_cpu_rst, 0);
        tick();
        chk("run1_end_pulse", c0_run_end, 1);
        chk("run1_timeout", c0_timeout, 1);
        chk("run1_idx", c0_idx, 1);
        chk("run1_cpu_rst_high", c0_cpu_rst, 1);

        wait_cond(0, 0, 7);
        hlt0 = 1'b1; tick(); hlt0 = 1'b0;
        chk("hlt7_halted", c0_halted, 1);
        chk("hlt7_hlt_cycle", c0_hc, 7);
        chk("hlt7_timeout", c0_timeout, 0);
        chk("hlt7_idx", c0_idx, 2);
        chk("hlt7_cpu_rst", c0_cpu_rst, 1);
        wait_cond(0, 0, 1);
        chk("next_run_halted_clear", c0_halted, 0);

        wait_cond(0, 0, 30);
        hlt0 = 1'b1; tick(); hlt0 = 1'b0;
        chk("hlt_at_expiry_halted", c0_halted, 1);
        chk("hlt_at_expiry_timeout", c0_timeout, 0);

        wait_cond(0, 0, 15);
        rst0 = 1'b1; tick(); rst0 = 1'b0;
        chk("midrun_rst_cpu_rst", c0_cpu_rst, 1);
        chk("midrun_rst_cycleNum", c0_cn, 1);
        chk("midrun_rst_idx", c0_idx, 0);

        rst1 = 1'b0;
        wait_cond(1, 0, 4);
        hlt1 = 1'b1; tick(); hlt1 = 1'b0;
        wait_cond(1, 0, 6);
        hlt1 = 1'b1; tick(); hlt1 = 1'b0;
        wait_cond(1, 1, 0);
        chk("soh0_hlt_cycle", c1_hc, 4);
        chk("soh0_halted", c1_halted, 1);
        chk("soh0_timeout", c1_timeout, 1);
        chk("soh0_cyc_wrap", c1_cyc_wrap, 1);
        chk("soh0_idx", c1_idx, 1);
        wait_cond(1, 2, 0);
        tick();
        chk("done_idx", c1_idx, 3);
        chk("done_cycleNum_frozen", c1_cn, 2);
        chk("done_cpu_rst", c1_cpu_rst, 1);
        chk("done_flag", c1_done, 1);

        for (int i = 0; i < 4000; i++) begin
            hlt0 = ($urandom % 30) == 0;
            hlt1 = ($urandom % 25) == 0;
            rst0 = ($urandom % 400) == 0;
            rst1 = ($urandom % 150) == 0;
            tick();
        end
        hlt0 = 1'b0; hlt1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
        tick();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
